// File: rtl/point_generator_pkg.sv
// -----------------------------------------------------------------------------
// point_generator_pkg
// Purpose : Constants and types shared by the point generator and the solver
//           side of the design (coordinate format, index widths, FSM states).
// Contents: COORD_WIDTH / COORD_FRAC  - signed Q7.20 coordinate format
//           COL_WIDTH / ROW_WIDTH     - raster index counter widths
//           state_t                   - IDLE / RUN / DONE state encoding
// -----------------------------------------------------------------------------
package point_generator_pkg;

   localparam int COORD_WIDTH = 27;
   localparam int COORD_FRAC  = 20;   // informational: no arithmetic uses it
   localparam int COL_WIDTH   = 11;
   localparam int ROW_WIDTH   = 11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/point_generator_axis_stepper.sv
// -----------------------------------------------------------------------------
// axis_stepper
// Purpose : One raster axis: a signed coordinate plus its index counter.
//           On load the window limits are latched and the axis restarts at
//           its minimum. On step it either advances by the latched increment
//           or, when the axis has reached its end, wraps back to the minimum.
// Ports   : clock, reset      - clock, asynchronous active-high reset
//           i_load            - latch i_min/i_max/i_inc, restart at i_min
//           i_step            - advance (or wrap when o_end is high)
//           i_min/i_max/i_inc - signed window edge (inclusive) and increment
//           o_coord / o_idx   - current coordinate and index
//           o_end             - next step would leave the window or the index
//                               counter is saturated
// -----------------------------------------------------------------------------
module axis_stepper #(
   parameter int WIDTH = 27,
   parameter int IDX_W = 11
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_min,
   input  logic [WIDTH-1:0] i_max,
   input  logic [WIDTH-1:0] i_inc,
   output logic [WIDTH-1:0] o_coord,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_end
);

   logic [WIDTH-1:0] r_min;
   logic [WIDTH-1:0] r_max;
   logic [WIDTH-1:0] r_inc;
   logic [WIDTH-1:0] r_coord;
   logic [IDX_W-1:0] r_idx;

   logic signed [WIDTH:0] w_next;
   logic signed [WIDTH:0] w_max_ext;

   // One extra bit so coordinate + increment can never wrap to a negative
   // value near the top of the coordinate range.
   assign w_next    = $signed({r_coord[WIDTH-1], r_coord}) + $signed({r_inc[WIDTH-1], r_inc});
   assign w_max_ext = $signed({r_max[WIDTH-1], r_max});

   assign o_end   = (w_next > w_max_ext) || (&r_idx);
   assign o_coord = r_coord;
   assign o_idx   = r_idx;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_min   <= '0;
         r_max   <= '0;
         r_inc   <= '0;
         r_coord <= '0;
         r_idx   <= '0;
      end else if (i_load) begin
         r_min   <= i_min;
         r_max   <= i_max;
         r_inc   <= i_inc;
         r_coord <= i_min;
         r_idx   <= '0;
      end else if (i_step) begin
         if (o_end) begin
            r_coord <= r_min;
            r_idx   <= '0;
         end else begin
            r_coord <= w_next[WIDTH-1:0];
            r_idx   <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/point_generator.sv
// -----------------------------------------------------------------------------
// point_generator
// Purpose : Walks a rectangular complex-plane window in raster order (rows
//           from min_y upward, columns from min_x rightward) and hands one
//           (x, y, col, row) point per valid/ready handshake to the solvers.
// Ports   : clock, reset        - clock, asynchronous active-high reset
//           start               - begin a frame (sampled only in IDLE)
//           min_x/min_y/max_x/max_y/dx/dy - signed window, latched at start
//           out_valid/out_ready - point handshake
//           out_x/out_y         - point coordinates
//           out_col/out_row     - raster indices of the point
//           out_last            - current point is the final one of the frame
//           busy                - frame in progress
//           done                - one-cycle pulse at frame end
// -----------------------------------------------------------------------------
module point_generator
   import point_generator_pkg::*;
#(
   parameter int WIDTH = COORD_WIDTH,
   parameter int COL_W = COL_WIDTH,
   parameter int ROW_W = ROW_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] min_x,
   input  logic [WIDTH-1:0] min_y,
   input  logic [WIDTH-1:0] max_x,
   input  logic [WIDTH-1:0] max_y,
   input  logic [WIDTH-1:0] dx,
   input  logic [WIDTH-1:0] dy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_x,
   output logic [WIDTH-1:0] out_y,
   output logic [COL_W-1:0] out_col,
   output logic [ROW_W-1:0] out_row,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   state_t r_state;
   state_t w_state_next;

   logic w_window_bad;
   logic w_load;
   logic w_handshake;
   logic w_x_end;
   logic w_y_end;
   logic w_frame_end;

   // Empty or non-advancing windows produce no points at all.
   assign w_window_bad = ($signed(min_x) > $signed(max_x)) ||
                         ($signed(min_y) > $signed(max_y)) ||
                         dx[WIDTH-1] || (dx == '0)         ||
                         dy[WIDTH-1] || (dy == '0);

   assign w_load      = (r_state == ST_IDLE) && start && !w_window_bad;
   assign w_handshake = (r_state == ST_RUN) && out_ready;
   assign w_frame_end = w_x_end && w_y_end;

   axis_stepper #(
      .WIDTH (WIDTH),
      .IDX_W (COL_W)
   ) u_x_axis (
      .clock   (clock),
      .reset   (reset),
      .i_load  (w_load),
      .i_step  (w_handshake),
      .i_min   (min_x),
      .i_max   (max_x),
      .i_inc   (dx),
      .o_coord (out_x),
      .o_idx   (out_col),
      .o_end   (w_x_end)
   );

   // The row axis only advances when the column axis wraps.
   axis_stepper #(
      .WIDTH (WIDTH),
      .IDX_W (ROW_W)
   ) u_y_axis (
      .clock   (clock),
      .reset   (reset),
      .i_load  (w_load),
      .i_step  (w_handshake && w_x_end),
      .i_min   (min_y),
      .i_max   (max_y),
      .i_inc   (dy),
      .o_coord (out_y),
      .o_idx   (out_row),
      .o_end   (w_y_end)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = w_window_bad ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_handshake && w_frame_end) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Status outputs decode the state register only, so out_ready never
   // reaches out_valid combinationally.
   assign out_valid = (r_state == ST_RUN);
   assign busy      = (r_state == ST_RUN);
   assign done      = (r_state == ST_DONE);
   assign out_last  = (r_state == ST_RUN) && w_frame_end;

endmodule

// File: tb/tb_point_generator.sv
// -----------------------------------------------------------------------------
// tb_point_generator
// Purpose : Directed self-checking bench for point_generator. Inputs change and
//           outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_point_generator;
   import point_generator_pkg::*;

   localparam int W    = COORD_WIDTH;
   localparam int CW   = COL_WIDTH;
   localparam int RW   = ROW_WIDTH;
   localparam int PW   = W + W + CW + RW + 1;
   localparam int MAXP = (1 << (W - 1)) - 1;

   logic          clock;
   logic          reset;
   logic          start;
   logic [W-1:0]  min_x, min_y, max_x, max_y, dx, dy;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_x, out_y;
   logic [CW-1:0] out_col;
   logic [RW-1:0] out_row;
   logic          out_last;
   logic          busy;
   logic          done;

   int checks   = 0;
   int failures = 0;
   int done_gap;
   logic [PW-1:0] pts[$];
   logic [PW-1:0] exp_pts[$];

   point_generator #(
      .WIDTH (W),
      .COL_W (CW),
      .ROW_W (RW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .min_x     (min_x),
      .min_y     (min_y),
      .max_x     (max_x),
      .max_y     (max_y),
      .dx        (dx),
      .dy        (dy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_col   (out_col),
      .out_row   (out_row),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [PW-1:0] pk(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [CW-1:0] c, input logic [RW-1:0] r,
                                        input logic l);
      return {x, y, c, r, l};
   endfunction

   function automatic logic [PW-1:0] cur();
      return pk(out_x, out_y, out_col, out_row, out_last);
   endfunction

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_window(input int mnx, input int mxx, input int ddx,
                             input int mny, input int mxy, input int ddy);
      min_x = mnx[W-1:0];
      max_x = mxx[W-1:0];
      dx    = ddx[W-1:0];
      min_y = mny[W-1:0];
      max_y = mxy[W-1:0];
      dy    = ddy[W-1:0];
   endtask

   // Pulse start for one cycle; one cycle later either a point is offered
   // (good window) or done is already pulsing (degenerate window).
   task automatic begin_frame(input string tag, input logic exp_valid);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check({tag, "_first_valid"}, out_valid, exp_valid);
      check({tag, "_early_done"}, done, !exp_valid);
   endtask

   // Accept points until done; bp randomises out_ready; poke >= 0 pulses
   // start with a different window at that cycle.
   task automatic collect(input string tag, input bit bp, input int budget, input int poke);
      logic [PW-1:0] prev;
      bit stalled;
      bit got_done;
      int last_hs;
      stalled  = 1'b0;
      got_done = 1'b0;
      last_hs  = -1;
      prev     = '0;
      done_gap = -1;
      pts.delete();
      for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
         if (stalled) check({tag, "_stall_hold"}, cur(), prev);
         if (done) begin
            got_done = 1'b1;
            done_gap = cyc - last_hs;
         end else begin
            if (cyc == poke) begin
               start = 1'b1;
               set_window(100, 200, 1, 100, 200, 1);
            end else begin
               start = 1'b0;
            end
            out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_valid && out_ready) begin
               pts.push_back(cur());
               last_hs = cyc;
            end
            stalled = out_valid && !out_ready;
            prev    = cur();
            @(negedge clock);
         end
      end
      start = 1'b0;
      check({tag, "_done_seen"}, got_done, 1'b1);
      if (got_done) begin
         check({tag, "_valid_in_done"}, out_valid, 1'b0);
         @(negedge clock);
         check({tag, "_done_one_cycle"}, done, 1'b0);
      end
   endtask

   task automatic compare_points(input string tag);
      check({tag, "_count"}, pts.size(), exp_pts.size());
      for (int i = 0; i < exp_pts.size(); i++) begin
         if (i < pts.size()) check($sformatf("%s_pt%0d", tag, i), pts[i], exp_pts[i]);
      end
   endtask

   task automatic load_small_expect();
      exp_pts.delete();
      exp_pts.push_back(pk(0, 0, 0, 0, 0));
      exp_pts.push_back(pk(4, 0, 1, 0, 0));
      exp_pts.push_back(pk(8, 0, 2, 0, 0));
      exp_pts.push_back(pk(0, 5, 0, 1, 0));
      exp_pts.push_back(pk(4, 5, 1, 1, 0));
      exp_pts.push_back(pk(8, 5, 2, 1, 1));
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      set_window(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clock);
      check("reset_point", cur(), pk(0, 0, 0, 0, 0));
      check("reset_flags", {out_valid, busy, done, out_last}, 4'b0000);
      reset = 1'b0;
      @(negedge clock);
      check("idle_flags", {out_valid, busy, done}, 3'b000);

      // Small window, always ready
      set_window(0, 10, 4, 0, 5, 5);
      begin_frame("small", 1'b1);
      check("small_busy", busy, 1'b1);
      collect("small", 1'b0, 50, -1);
      load_small_expect();
      compare_points("small");
      check("small_done_gap", done_gap, 1);
      $display("small window: %0d points", pts.size());

      // Same window with random backpressure
      set_window(0, 10, 4, 0, 5, 5);
      begin_frame("bp", 1'b1);
      collect("bp", 1'b1, 300, -1);
      compare_points("bp");
      $display("backpressure window: %0d points", pts.size());

      // start pulsed mid-frame with another window is ignored
      set_window(0, 10, 4, 0, 5, 5);
      begin_frame("restart", 1'b1);
      collect("restart", 1'b0, 50, 2);
      compare_points("restart");
      $display("start during run: %0d points", pts.size());

      // Negative coordinates, signed compares
      set_window(-10, -3, 3, -2, -2, 7);
      begin_frame("neg", 1'b1);
      collect("neg", 1'b0, 50, -1);
      exp_pts.delete();
      exp_pts.push_back(pk(-10, -2, 0, 0, 0));
      exp_pts.push_back(pk(-7, -2, 1, 0, 0));
      exp_pts.push_back(pk(-4, -2, 2, 0, 1));
      compare_points("neg");
      $display("negative window: %0d points", pts.size());

      // Right edge at the top of the coordinate range: x+dx must not wrap
      set_window(MAXP - 4, MAXP, 3, 0, 0, 1);
      begin_frame("ovf", 1'b1);
      collect("ovf", 1'b0, 50, -1);
      exp_pts.delete();
      exp_pts.push_back(pk(MAXP - 4, 0, 0, 0, 0));
      exp_pts.push_back(pk(MAXP - 1, 0, 1, 0, 1));
      compare_points("ovf");
      $display("overflow-edge window: %0d points", pts.size());

      // Column counter saturation ends the row at col 2047
      set_window(0, 5000, 1, 0, 0, 1);
      begin_frame("colsat", 1'b1);
      collect("colsat", 1'b0, 2200, -1);
      check("colsat_count", pts.size(), 2048);
      if (pts.size() == 2048) begin
         check("colsat_first", pts[0], pk(0, 0, 0, 0, 0));
         check("colsat_penult", pts[2046], pk(2046, 0, 2046, 0, 0));
         check("colsat_last", pts[2047], pk(2047, 0, 2047, 0, 1));
      end
      $display("column saturation: %0d points", pts.size());

      // Row counter saturation ends the frame at row 2047
      set_window(0, 0, 1, 0, 5000, 1);
      begin_frame("rowsat", 1'b1);
      collect("rowsat", 1'b0, 2200, -1);
      check("rowsat_count", pts.size(), 2048);
      if (pts.size() == 2048) begin
         check("rowsat_second", pts[1], pk(0, 1, 0, 1, 0));
         check("rowsat_last", pts[2047], pk(0, 2047, 0, 2047, 1));
      end
      $display("row saturation: %0d points", pts.size());

      // Degenerate windows: no points, done straight away
      set_window(0, 10, 0, 0, 5, 5);
      begin_frame("dx0", 1'b0);
      collect("dx0", 1'b0, 10, -1);
      check("dx0_count", pts.size(), 0);
      $display("dx=0 window: %0d points", pts.size());

      set_window(11, 10, 1, 0, 5, 5);
      begin_frame("minx_gt", 1'b0);
      collect("minx_gt", 1'b0, 10, -1);
      check("minx_gt_count", pts.size(), 0);
      $display("min_x>max_x window: %0d points", pts.size());

      // Single-point window
      set_window(3 << 20, 3 << 20, 1, -(1 << 20), -(1 << 20), 1);
      begin_frame("single", 1'b1);
      check("single_last_comb", out_last, 1'b1);
      collect("single", 1'b0, 10, -1);
      exp_pts.delete();
      exp_pts.push_back(pk(3 << 20, -(1 << 20), 0, 0, 1));
      compare_points("single");
      $display("single-point window: %0d points", pts.size());

      // Asynchronous reset after the 3rd handshake
      set_window(0, 10, 4, 0, 5, 5);
      begin_frame("rst", 1'b1);
      out_ready = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_pre_point", cur(), pk(0, 5, 0, 1, 0));
      #2 reset = 1'b1;
      #1;
      check("rst_async_flags", {out_valid, busy}, 2'b00);
      check("rst_async_point", cur(), pk(0, 0, 0, 0, 0));
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_idle_valid", out_valid, 1'b0);
      begin_frame("rst_again", 1'b1);
      check("rst_again_first", cur(), pk(0, 0, 0, 0, 0));
      collect("rst_again", 1'b0, 50, -1);
      load_small_expect();
      compare_points("rst_again");
      $display("reset mid-frame then restart: %0d points", pts.size());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
